// File: rtl/dispatch_queue_if.sv
// Enqueue/dequeue bundle of the dual-wide dispatch queue.
// master = rename/issue side, slave = the queue itself.
interface dispatch_queue_if #(
    parameter int UOP_W = 128,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               enq_valid_i;
    logic [1:0]         enq_mask_i;
    logic [2*UOP_W-1:0] enq_uop_i;
    logic               enq_ready_o;
    logic [1:0]         deq_valid_o;
    logic [2*UOP_W-1:0] deq_uop_o;
    logic [1:0]         deq_cnt_i;
    logic [CNT_W-1:0]   count_o;

    modport master (
        output enq_valid_i, enq_mask_i, enq_uop_i, deq_cnt_i,
        input  enq_ready_o, deq_valid_o, deq_uop_o, count_o
    );

    modport slave (
        input  enq_valid_i, enq_mask_i, enq_uop_i, deq_cnt_i,
        output enq_ready_o, deq_valid_o, deq_uop_o, count_o
    );
endinterface

// File: rtl/dispatch_queue.sv
// Dual-wide in-order dispatch queue: up to two uops in and two out per cycle, flushable.
// Optional perf counters (full stalls, empty cycles) enabled by DISPATCH_QUEUE_PERF_EN.
module dispatch_queue #(
    parameter int UOP_W = 128,
    parameter int DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    dispatch_queue_if.slave   q
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    output logic [31:0]       full_stall_cnt_o,
    output logic [31:0]       empty_cnt_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [UOP_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             enq_ready, enq_fire, wr_allow;
    logic [1:0]       n_enq, n_avail, n_deq;
    logic [UOP_W-1:0] wr_data0, wr_data1;
    logic [DEPTH-1:0] we0, we1;

    // Ready looks only at the registered count, so it never waits on this cycle's dequeue.
    assign enq_ready = (count_reg <= CNT_W'(DEPTH - 2));
    assign enq_fire  = q.enq_valid_i & enq_ready;
    assign wr_allow  = enq_fire & ~rst_i & ~flush_i;
    assign head_p1   = head_reg + PTR_W'(1);
    assign tail_p1   = tail_reg + PTR_W'(1);

    always_comb begin
        n_enq = 2'd0;
        if (enq_fire) begin
            n_enq = {1'b0, q.enq_mask_i[0]} + {1'b0, q.enq_mask_i[1]};
        end
        n_avail = (count_reg >= CNT_W'(2)) ? 2'd2 : count_reg[1:0];
        // Over-requests (including 3) are clamped to what is actually at the head.
        n_deq = (q.deq_cnt_i > n_avail) ? n_avail : q.deq_cnt_i;
        // Compaction: the first written entry is slot 0 if present, otherwise slot 1.
        wr_data0   = q.enq_mask_i[0] ? q.enq_uop_i[UOP_W-1:0] : q.enq_uop_i[2*UOP_W-1:UOP_W];
        wr_data1   = q.enq_uop_i[2*UOP_W-1:UOP_W];
        head_next  = head_reg + PTR_W'(n_deq);
        tail_next  = tail_reg + PTR_W'(n_enq);
        count_next = count_reg + CNT_W'(n_enq) - CNT_W'(n_deq);
    end

    // Per-entry write enables; tail+1 wraps naturally, splitting a pair across DEPTH-1 -> 0.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we0[gi] = wr_allow && (n_enq != 2'd0) && (tail_reg == PTR_W'(gi));
        assign we1[gi] = wr_allow && (n_enq == 2'd2) && (tail_p1 == PTR_W'(gi));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we0[i]) begin
                mem_reg[i] <= wr_data0;
            end else if (we1[i]) begin
                mem_reg[i] <= wr_data1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Valid bits come from the count alone, so unwritten payload never leaks into them.
    assign q.enq_ready_o = enq_ready;
    assign q.deq_valid_o = {count_reg >= CNT_W'(2), count_reg != '0};
    assign q.deq_uop_o   = {mem_reg[head_p1], mem_reg[head_reg]};
    assign q.count_o     = count_reg;

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] full_stall_cnt_reg, empty_cnt_reg;

    // Flush intentionally leaves these alone; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_stall_cnt_reg <= '0;
            empty_cnt_reg      <= '0;
        end else begin
            if (q.enq_valid_i && !enq_ready) begin
                full_stall_cnt_reg <= full_stall_cnt_reg + 32'd1;
            end
            if (count_reg == '0) begin
                empty_cnt_reg <= empty_cnt_reg + 32'd1;
            end
        end
    end

    assign full_stall_cnt_o = full_stall_cnt_reg;
    assign empty_cnt_o      = empty_cnt_reg;
`endif
endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: vector table plus hand sequences, with a
// reference FIFO acting as scoreboard for payload order.
module tb_dispatch_queue;
    localparam int UOP_W = 128;
    localparam int DEPTH = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;

    dispatch_queue_if #(.UOP_W(UOP_W), .DEPTH(DEPTH)) q ();

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] full_stall_cnt_o, empty_cnt_o;
    int unsigned exp_stall, exp_empty;
`endif

    dispatch_queue #(.UOP_W(UOP_W), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .q       (q)
`ifdef DISPATCH_QUEUE_PERF_EN
        ,
        .full_stall_cnt_o (full_stall_cnt_o),
        .empty_cnt_o      (empty_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         ev;
        logic [1:0] mask;
        logic [1:0] dc;
        int         exp_count;
        bit         exp_ready;
        logic [1:0] exp_valid;
    } vec_t;

    vec_t vecs[11];
    logic [UOP_W-1:0] model[$];
    int errors = 0;
    int checks = 0;
    int seq = 0;
    int step_no = 0;

    function automatic logic [UOP_W-1:0] uop_of(input int k);
        bit [31:0] kk;
        kk = k;
        return {32'hD15A_0000 | kk, ~kk, kk * 32'd3, kk ^ 32'h5A5A_5A5A};
    endfunction

    function automatic void check(input string name, input logic [UOP_W-1:0] act,
                                  input logic [UOP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Compare DUT state against the reference FIFO.
    task automatic check_model();
        int sz;
        sz = model.size();
        check("count", UOP_W'(q.count_o), UOP_W'(sz));
        check("enq_ready", UOP_W'(q.enq_ready_o), UOP_W'((DEPTH - sz) >= 2));
        check("deq_valid", UOP_W'(q.deq_valid_o), UOP_W'({sz >= 2, sz >= 1}));
        if (sz >= 1) check("head0_uop", q.deq_uop_o[UOP_W-1:0], model[0]);
        if (sz >= 2) check("head1_uop", q.deq_uop_o[2*UOP_W-1:UOP_W], model[1]);
`ifdef DISPATCH_QUEUE_PERF_EN
        check("full_stall_cnt", UOP_W'(full_stall_cnt_o), UOP_W'(exp_stall));
        check("empty_cnt", UOP_W'(empty_cnt_o), UOP_W'(exp_empty));
`endif
    endtask

    // One clock cycle: drive at negedge, update the reference, sample 1 time unit after posedge.
    task automatic step(input bit rst, input bit fl, input bit ev,
                        input logic [1:0] mask, input logic [1:0] dc);
        bit rdy;
        int nv, nd, sz;
        @(negedge clk_i);
        rst_i         = rst;
        flush_i       = fl;
        q.enq_valid_i = ev;
        q.enq_mask_i  = mask;
        q.enq_uop_i   = {uop_of(seq + 1), uop_of(seq)};
        q.deq_cnt_i   = dc;
        sz  = model.size();
        rdy = (DEPTH - sz) >= 2;
        nv  = (sz >= 2) ? 2 : sz;
        if (!rst && !fl && int'(dc) > nv)
            $display("note: illegal deq_cnt=%0d with %0d valid heads (clamped)", dc, nv);
`ifdef DISPATCH_QUEUE_PERF_EN
        if (rst) begin
            exp_stall = 0;
            exp_empty = 0;
        end else begin
            if (ev && !rdy) exp_stall++;
            if (sz == 0) exp_empty++;
        end
`endif
        if (rst || fl) begin
            model.delete();
        end else begin
            nd = (int'(dc) > nv) ? nv : int'(dc);
            repeat (nd) void'(model.pop_front());
            if (ev && rdy) begin
                if (mask[0]) model.push_back(uop_of(seq));
                if (mask[1]) model.push_back(uop_of(seq + 1));
                seq += 2;
            end
        end
        @(posedge clk_i);
        #1;
        step_no++;
        $display("step %0d rst=%0b fl=%0b ev=%0b mask=%b dc=%0d -> count=%0d ready=%0b valid=%b",
                 step_no, rst, fl, ev, mask, dc, q.count_o, q.enq_ready_o, q.deq_valid_o);
        check_model();
    endtask

    task automatic idle(input logic [1:0] dc);
        step(1'b0, 1'b0, 1'b0, 2'b00, dc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        q.enq_valid_i = 1'b0; q.enq_mask_i = 2'b00; q.enq_uop_i = '0; q.deq_cnt_i = 2'd0;
`ifdef DISPATCH_QUEUE_PERF_EN
        exp_stall = 0; exp_empty = 0;
`endif
        //            ev  mask   dc     cnt rdy valid
        vecs[0]  = '{1'b1, 2'b10, 2'd0, 1, 1'b1, 2'b01};
        vecs[1]  = '{1'b1, 2'b11, 2'd0, 3, 1'b1, 2'b11};
        vecs[2]  = '{1'b0, 2'b00, 2'd2, 1, 1'b1, 2'b01};
        vecs[3]  = '{1'b1, 2'b00, 2'd0, 1, 1'b1, 2'b01};
        vecs[4]  = '{1'b1, 2'b01, 2'd1, 1, 1'b1, 2'b01};
        vecs[5]  = '{1'b0, 2'b00, 2'd3, 0, 1'b1, 2'b00};
        vecs[6]  = '{1'b0, 2'b00, 2'd2, 0, 1'b1, 2'b00};
        vecs[7]  = '{1'b1, 2'b11, 2'd0, 2, 1'b1, 2'b11};
        vecs[8]  = '{1'b1, 2'b11, 2'd1, 3, 1'b1, 2'b11};
        vecs[9]  = '{1'b0, 2'b00, 2'd3, 1, 1'b1, 2'b01};
        vecs[10] = '{1'b0, 2'b00, 2'd1, 0, 1'b1, 2'b00};

        // Reset, then 10 idle cycles in the reset state.
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        for (int i = 0; i < 10; i++) begin
            idle(2'd2);
            check("idle_count", UOP_W'(q.count_o), '0);
            check("idle_ready", UOP_W'(q.enq_ready_o), UOP_W'(1));
            check("idle_valid", UOP_W'(q.deq_valid_o), '0);
        end

        // Table: compaction, mask 00, clamping, empty dequeue.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, vecs[i].ev, vecs[i].mask, vecs[i].dc);
            check($sformatf("vec%0d_count", i), UOP_W'(q.count_o), UOP_W'(vecs[i].exp_count));
            check($sformatf("vec%0d_ready", i), UOP_W'(q.enq_ready_o), UOP_W'(vecs[i].exp_ready));
            check($sformatf("vec%0d_valid", i), UOP_W'(q.deq_valid_o), UOP_W'(vecs[i].exp_valid));
            // After B then C,D: oldest B (slot 1 of first offer), then C.
            if (i == 1) begin
                check("compact_low_B", q.deq_uop_o[UOP_W-1:0], uop_of(1));
                check("compact_high_C", q.deq_uop_o[2*UOP_W-1:UOP_W], uop_of(2));
            end
            if (i == 2) check("compact_head_D", q.deq_uop_o[UOP_W-1:0], uop_of(3));
        end

        // Fill with pairs and exercise backpressure.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
            check("fill_count", UOP_W'(q.count_o), UOP_W'(2 * k));
            check("fill_ready", UOP_W'(q.enq_ready_o), UOP_W'(k < 8));
        end
        step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        check("held_full_count", UOP_W'(q.count_o), UOP_W'(16));
        step(1'b0, 1'b0, 1'b1, 2'b11, 2'd2);
        check("held_deq_count", UOP_W'(q.count_o), UOP_W'(14));
        step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        check("held_enter_count", UOP_W'(q.count_o), UOP_W'(16));
        idle(2'd1);
        check("cnt15_ready", UOP_W'(q.enq_ready_o), '0);
        step(1'b0, 1'b0, 1'b1, 2'b01, 2'd0);
        check("cnt15_single_ignored", UOP_W'(q.count_o), UOP_W'(15));
        repeat (7) idle(2'd2);
        idle(2'd1);

        // Wrap-around: reset, park head=tail=15, then write a straddling pair.
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        repeat (7) step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'b01, 2'd0);
        repeat (7) idle(2'd2);
        idle(2'd1);
        check("wrap_empty", UOP_W'(q.count_o), '0);
        step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        check("wrap_X_low", q.deq_uop_o[UOP_W-1:0], uop_of(seq - 2));
        check("wrap_Y_high", q.deq_uop_o[2*UOP_W-1:UOP_W], uop_of(seq - 1));

        // Concurrent two-in/two-out at count 14.
        repeat (6) step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 2'b11, 2'd2);
            check("concurrent_count", UOP_W'(q.count_o), UOP_W'(14));
        end

        // Flush at count 7 with enqueue and dequeue in the same cycle.
        repeat (3) idle(2'd2);
        idle(2'd1);
        check("preflush_count", UOP_W'(q.count_o), UOP_W'(7));
        step(1'b0, 1'b1, 1'b1, 2'b11, 2'd2);
        check("flush_count", UOP_W'(q.count_o), '0);
        check("flush_valid", UOP_W'(q.deq_valid_o), '0);
        check("flush_ready", UOP_W'(q.enq_ready_o), UOP_W'(1));
        repeat (2) idle(2'd2);
        step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        check("postflush_head", q.deq_uop_o[UOP_W-1:0], uop_of(seq - 2));

        // Reset mid-stream at count 7.
        repeat (2) step(1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'b01, 2'd0);
        check("prereset_count", UOP_W'(q.count_o), UOP_W'(7));
        step(1'b1, 1'b0, 1'b1, 2'b11, 2'd2);
        check("reset_count", UOP_W'(q.count_o), '0);
        check("reset_valid", UOP_W'(q.deq_valid_o), '0);
        check("reset_ready", UOP_W'(q.enq_ready_o), UOP_W'(1));
`ifdef DISPATCH_QUEUE_PERF_EN
        check("reset_stall_cnt", UOP_W'(full_stall_cnt_o), '0);
        check("reset_empty_cnt", UOP_W'(empty_cnt_o), '0);
`endif
        idle(2'd0);
        step(1'b0, 1'b0, 1'b1, 2'b10, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
